uart_tx_frame: RTL and testbench

UART transmit framer: the transmit-side counterpart of the receive path's sampler, start, parity and stop checking. It accepts one parallel byte on a valid/busy handshake and serialises it as start bit, 8 data bits LSB-first, an optional parity bit and one stop bit. Each bit is held for a programmable number of clock cycles. Prescale and parity encodings match the receiver, so a TX→RX loopback with identical configuration raises no error flags.

---
 rtl/uart_tx_frame.sv | 125 ++++++++++++
 tb/tb_uart_tx_frame.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Each bit is held for a prescaled number of clocks; outputs are registered.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [1:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [4:0]            last_q;
    logic [4:0]            edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_next;
    logic                  bit_end;

    // Prescale is stored as N-1 so a bit ends on a plain equality compare.
    function automatic logic [4:0] last_edge(input logic [1:0] p);
        case (p)
            2'b00:   return 5'd0;
            2'b01:   return 5'd7;
            2'b10:   return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    assign bit_end  = (edge_cnt == last_q);
    assign bit_next = bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            last_q    <= 5'd0;
            edge_cnt  <= 5'd0;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            edge_cnt <= bit_end ? 5'd0 : edge_cnt + 5'd1;
            case (state)
                IDLE: begin
                    edge_cnt <= 5'd0;
                    bit_cnt  <= '0;
                    TX_OUT   <= 1'b1;
                    busy     <= 1'b0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        last_q    <= last_edge(Prescale);
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        TX_OUT  <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= par_typ_q ? ~^data_q : ^data_q;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_next;
                            TX_OUT  <= data_q[bit_next];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: checks every serial bit cycle by cycle
// against a small frame model plus hand-computed parity and frame lengths.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    logic [10:0] cap;
    int          blen;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (pe) f[9] = pt ? ~^d : ^d;
        return f;
    endfunction

    // Sends one frame and checks TX_OUT/busy on every cycle; cap holds the
    // first sample of each bit, blen the number of busy-high cycles.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [1:0] ps, input bit disturb);
        int n;
        int nbits;
        int guard;
        logic [10:0] exp;
        n     = (ps == 2'b00) ? 1 : (ps == 2'b01) ? 8 : (ps == 2'b10) ? 16 : 32;
        nbits = pe ? 11 : 10;
        exp   = frame_bits(d, pe, pt);
        cap   = '1;
        blen  = 0;
        @(negedge clk);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < n; c++) begin
                check("tx_bit", {31'd0, TX_OUT}, {31'd0, exp[b]});
                check("busy_in_frame", {31'd0, busy}, 32'd1);
                if (c == 0) cap[b] = TX_OUT;
                if (busy) blen++;
                if (disturb && b == 4 && c == 0) begin
                    DATA_VALID = 1'b1; P_DATA = 8'hFF; Prescale = 2'b00; PAR_EN = 1'b1;
                end
                if (disturb && b == 4 && c == 1) DATA_VALID = 1'b0;
                @(negedge clk);
            end
        end
        guard = 0;
        while (busy && guard < 400) begin
            blen++;
            guard++;
            @(negedge clk);
        end
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        check("tx_idle_after_frame", {31'd0, TX_OUT}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] b2b_tx;
        logic [21:0] b2b_busy;
        int          extra;

        rst = 1'b1; P_DATA = 8'h00; DATA_VALID = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5, N=1, no parity: spec sequence 0,1,0,1,0,0,1,0,1,1
        run_frame(8'hA5, 1'b0, 1'b0, 2'b00, 1'b0);
        check("a5_sequence", {22'd0, cap[9:0]}, {22'd0, 10'b11_0100_1010});
        check("a5_len", blen, 32'd10);

        run_frame(8'h03, 1'b1, 1'b0, 2'b01, 1'b0);
        check("even_03_parity", {31'd0, cap[9]}, 32'd0);
        check("even_03_len", blen, 32'd88);

        run_frame(8'h01, 1'b1, 1'b1, 2'b10, 1'b0);
        check("odd_01_parity", {31'd0, cap[9]}, 32'd0);
        check("odd_01_len", blen, 32'd176);

        run_frame(8'h00, 1'b1, 1'b1, 2'b10, 1'b0);
        check("odd_00_parity", {31'd0, cap[9]}, 32'd1);
        check("odd_00_len", blen, 32'd176);

        // Mid-frame DATA_VALID/config changes must be ignored and not queued
        run_frame(8'h5A, 1'b0, 1'b0, 2'b11, 1'b1);
        check("ignore_len", blen, 32'd320);
        check("ignore_data", {24'd0, cap[8:1]}, 32'h5A);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) extra++;
            @(negedge clk);
        end
        check("no_second_frame", extra, 32'd0);

        // Reset during data bit 3 of 0x30 at N=8
        @(negedge clk);
        P_DATA = 8'h30; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 2'b01; DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        repeat (34) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_tx_bit3", {31'd0, TX_OUT}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("post_reset_still_idle", {31'd0, busy}, 32'd0);

        run_frame(8'h81, 1'b1, 1'b0, 2'b01, 1'b0);
        check("after_reset_data", {24'd0, cap[8:1]}, 32'h81);
        check("after_reset_parity", {31'd0, cap[9]}, 32'd0);
        check("after_reset_len", blen, 32'd88);

        // Back-to-back, DATA_VALID held: 0x00 then 0xFF, N=1
        @(negedge clk);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 2'b00; DATA_VALID = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            b2b_tx[i]   = TX_OUT;
            b2b_busy[i] = busy;
            if (i == 0) P_DATA = 8'hFF;
            if (i == 11) DATA_VALID = 1'b0;
        end
        // index 0..9 frame 0x00, 10 idle, 11..20 frame 0xFF, 21 idle
        check("b2b_tx", {10'd0, b2b_tx}, {10'd0, 22'b11_1111_1111_0110_0000_0000});
        check("b2b_busy", {10'd0, b2b_busy}, {10'd0, 22'b01_1111_1111_1011_1111_1111});
        check("b2b_start0", {31'd0, b2b_tx[0]}, 32'd0);
        check("b2b_stop0", {31'd0, b2b_tx[9]}, 32'd1);
        check("b2b_start1", {31'd0, b2b_tx[11]}, 32'd0);
        check("b2b_stop1", {31'd0, b2b_tx[20]}, 32'd1);
        repeat (5) @(negedge clk);
        check("b2b_no_third", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
